// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-memory port bundle for mem_access_unit.
// slave = the access unit, master = the MEM stage / memory side driving it.
interface mem_access_unit_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] dm_addr;
  logic              dm_bitop;
  logic              dm_extop;
  logic              dm_we;
  logic              dm_memread;
  logic [31:0]       dm_din;
  logic [31:0]       dm_dout;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, dm_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dm_addr, dm_bitop, dm_extop, dm_we, dm_memread, dm_din
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, dm_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dm_addr, dm_bitop, dm_extop, dm_we, dm_memread, dm_din
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: one load/store in flight, halfwords split
// into two byte beats (low byte first), misaligned requests answered with an
// error and no memory traffic. All outputs are registered.
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b111;
  localparam logic [2:0] OP_SH  = 3'b110;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_hi;   // SH high byte, sent on beat 1
  logic              beat;
  logic [7:0]        lo_q;       // halfword low byte from beat 0

  logic              req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic              dm_bitop_q, dm_we_q, dm_memread_q;
  logic [31:0]       dm_din_q;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.dm_addr    = dm_addr_q;
  assign bus.dm_bitop   = dm_bitop_q;
  assign bus.dm_extop   = 1'b0;  // extension is done here, memory returns raw bytes
  assign bus.dm_we      = dm_we_q;
  assign bus.dm_memread = dm_memread_q;
  assign bus.dm_din     = dm_din_q;

  // Decode of the incoming request and of the latched one.
  logic in_store, in_word, in_half, in_misal;
  logic q_store, q_half;
  assign in_store = bus.req_op[2] & (|bus.req_op[1:0]);
  assign in_word  = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
  assign in_half  = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);
  assign in_misal = (in_word && (bus.req_addr[1:0] != 2'b00)) || (in_half && bus.req_addr[0]);
  assign q_store  = op_q[2] & (|op_q[1:0]);
  assign q_half   = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);

  // Final load result, built from the byte/word arriving this WAIT cycle.
  logic [31:0] load_data;
  always_comb begin
    load_data = '0;
    case (op_q)
      OP_LB:   load_data = {{24{bus.dm_dout[7]}}, bus.dm_dout[7:0]};
      OP_LBU:  load_data = {24'h0, bus.dm_dout[7:0]};
      OP_LH:   load_data = {{16{bus.dm_dout[7]}}, bus.dm_dout[7:0], lo_q};
      OP_LHU:  load_data = {16'h0, bus.dm_dout[7:0], lo_q};
      OP_LW:   load_data = bus.dm_dout;
      default: load_data = '0;
    endcase
  end

  // Control FSM; memory strobes default low each cycle and are re-armed only
  // for the cycle that enters ISSUE, so reset or RESP leave the port quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_hi     <= '0;
      beat         <= 1'b0;
      lo_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      dm_addr_q    <= '0;
      dm_bitop_q   <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_memread_q <= 1'b0;
      dm_din_q     <= '0;
    end else begin
      dm_addr_q    <= '0;
      dm_bitop_q   <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_memread_q <= 1'b0;
      dm_din_q     <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            addr_q      <= bus.req_addr;
            wdata_hi    <= bus.req_wdata[15:8];
            beat        <= 1'b0;
            req_ready_q <= 1'b0;
            if (in_misal) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state        <= ISSUE;
              dm_addr_q    <= bus.req_addr;
              dm_bitop_q   <= ~in_word;
              dm_we_q      <= in_store;
              dm_memread_q <= ~in_store;
              if (in_store)
                dm_din_q <= in_word ? bus.req_wdata : {24'h0, bus.req_wdata[7:0]};
            end
          end
        end
        ISSUE: begin
          if (q_store) begin
            if (q_half && !beat) begin
              beat       <= 1'b1;
              dm_addr_q  <= addr_q + ADDR_W'(1);
              dm_bitop_q <= 1'b1;
              dm_we_q    <= 1'b1;
              dm_din_q   <= {24'h0, wdata_hi};
            end else begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= '0;
            end
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (q_half && !beat) begin
            lo_q         <= bus.dm_dout[7:0];
            beat         <= 1'b1;
            state        <= ISSUE;
            dm_addr_q    <= addr_q + ADDR_W'(1);
            dm_bitop_q   <= 1'b1;
            dm_memread_q <= 1'b1;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed memory model.
module tb_mem_access_unit;
  localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                         LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(12)) bus ();
  mem_access_unit #(.ADDR_W(12)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  // memory model: synchronous read, data one cycle after dm_memread
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.dm_we) begin
      if (bus.dm_bitop) mem[bus.dm_addr] <= bus.dm_din[7:0];
      else begin
        mem[{bus.dm_addr[11:2], 2'd0}] <= bus.dm_din[7:0];
        mem[{bus.dm_addr[11:2], 2'd1}] <= bus.dm_din[15:8];
        mem[{bus.dm_addr[11:2], 2'd2}] <= bus.dm_din[23:16];
        mem[{bus.dm_addr[11:2], 2'd3}] <= bus.dm_din[31:24];
      end
    end
    if (bus.dm_memread) begin
      if (bus.dm_bitop) bus.dm_dout <= {24'h0, mem[bus.dm_addr]};
      else bus.dm_dout <= {mem[{bus.dm_addr[11:2], 2'd3}], mem[{bus.dm_addr[11:2], 2'd2}],
                           mem[{bus.dm_addr[11:2], 2'd1}], mem[{bus.dm_addr[11:2], 2'd0}]};
    end
  end

  // port activity monitor
  int cyc = 0, we_cnt = 0, we_word_cnt = 0, rd_cnt = 0, both_cnt = 0;
  int we_cyc_prev = 0, we_cyc_last = 0;
  logic [11:0] we_addr_prev = '0, we_addr_last = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.dm_we) begin
      we_cnt       <= we_cnt + 1;
      we_addr_prev <= we_addr_last;
      we_addr_last <= bus.dm_addr;
      we_cyc_prev  <= we_cyc_last;
      we_cyc_last  <= cyc;
      if (!bus.dm_bitop) we_word_cnt <= we_word_cnt + 1;
    end
    if (bus.dm_memread) rd_cnt <= rd_cnt + 1;
    if (bus.dm_we && bus.dm_memread) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from idle; returns result and edges-to-resp_valid.
  // With resp_ready high the handshake edge is consumed before returning.
  task automatic do_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
    bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    err = bus.resp_err;
    if (bus.resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, w0, ww0, a0, saw;
  logic [2:0]  mis_op [3];
  logic [11:0] mis_addr [3];

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp", {bus.resp_rdata[30:0], bus.resp_valid}, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_dm_ctl", {28'h0, bus.dm_we, bus.dm_memread, bus.dm_bitop, bus.dm_extop}, 32'd0);
    chk("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    chk("rst_dm_din", bus.dm_din, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // word store then load
    w0 = we_cnt; ww0 = we_word_cnt;
    do_req(SW, 12'h010, 32'hDEADBEEF, rd, err, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(err), 32'd0);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("sw_word_we", 32'(we_word_cnt - ww0), 32'd1);
    do_req(LW, 12'h010, 32'h0, rd, err, lat);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(err), 32'd0);

    // byte loads
    do_req(LB, 12'h013, 32'h0, rd, err, lat);
    chk("lb13_rdata", rd, 32'hFFFFFFDE);
    chk("lb13_lat", 32'(lat), 32'd3);
    do_req(LBU, 12'h013, 32'h0, rd, err, lat);
    chk("lbu13_rdata", rd, 32'h000000DE);
    do_req(LB, 12'h010, 32'h0, rd, err, lat);
    chk("lb10_rdata", rd, 32'hFFFFFFEF);

    // byte store, read back
    do_req(SB, 12'h031, 32'hFFFFFF7C, rd, err, lat);
    chk("sb_lat", 32'(lat), 32'd2);
    do_req(LBU, 12'h031, 32'h0, rd, err, lat);
    chk("sb_readback", rd, 32'h0000007C);

    // halfword store: two byte beats on consecutive cycles
    w0 = we_cnt;
    do_req(SH, 12'h022, 32'h000080A5, rd, err, lat);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_we_pulses", 32'(we_cnt - w0), 32'd2);
    chk("sh_beat0_addr", 32'(we_addr_prev), 32'h022);
    chk("sh_beat1_addr", 32'(we_addr_last), 32'h023);
    chk("sh_consecutive", 32'(we_cyc_last - we_cyc_prev), 32'd1);
    do_req(LH, 12'h022, 32'h0, rd, err, lat);
    chk("lh_rdata", rd, 32'hFFFF80A5);
    chk("lh_lat", 32'(lat), 32'd5);
    do_req(LHU, 12'h022, 32'h0, rd, err, lat);
    chk("lhu_rdata", rd, 32'h000080A5);
    chk("lhu_lat", 32'(lat), 32'd5);

    // misaligned requests
    mis_op[0] = LW; mis_addr[0] = 12'h011;
    mis_op[1] = SW; mis_addr[1] = 12'h012;
    mis_op[2] = LH; mis_addr[2] = 12'h021;
    for (int i = 0; i < 3; i++) begin
      a0 = we_cnt + rd_cnt;
      do_req(mis_op[i], mis_addr[i], 32'h12345678, rd, err, lat);
      chk($sformatf("mis%0d_err", i), 32'(err), 32'd1);
      chk($sformatf("mis%0d_rdata", i), rd, 32'd0);
      chk($sformatf("mis%0d_lat", i), 32'(lat), 32'd1);
      chk($sformatf("mis%0d_activity", i), 32'(we_cnt + rd_cnt - a0), 32'd0);
    end

    // back-pressure on an LW; req_valid pulses must be ignored
    bus.resp_ready = 1'b0;
    do_req(LW, 12'h010, 32'h0, rd, err, lat);
    chk("bp_lat", 32'(lat), 32'd3);
    w0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = (i % 2 == 0); bus.req_op = SW; bus.req_addr = 12'h030;
      bus.req_wdata = 32'h0BADF00D;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("bp%0d_rdata", i), bus.resp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_store", 32'(we_cnt - w0), 32'd0);

    // reset during WAIT of LH beat 0
    bus.req_op = LH; bus.req_addr = 12'h022; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_in_wait", {30'h0, bus.dm_we, bus.dm_memread}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_dm_ctl", {28'h0, bus.dm_we, bus.dm_memread, bus.dm_bitop, bus.dm_extop}, 32'd0);
    chk("rstmid_dm_addr", 32'(bus.dm_addr), 32'd0);
    chk("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    saw = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.resp_valid) saw++;
    end
    chk("rstmid_no_resp", 32'(saw), 32'd0);
    do_req(LHU, 12'h022, 32'h0, rd, err, lat);
    chk("post_rst_lhu", rd, 32'h000080A5);

    chk("we_and_read_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
